// File: rtl/wall_pkg.sv
// Shared types and defaults for the wall sprite fetch path.
package wall_pkg;

  localparam int unsigned NREQ_DEFAULT = 3;
  localparam int unsigned AW_DEFAULT   = 10;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  // Requester id width; a single requester still needs one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/wall_fetch_arbiter_rr.sv
// Combinational round-robin pick: first request at or after ptr, wrapping to 0.
module rr_arbiter
  import wall_pkg::*;
#(
  parameter int unsigned N  = NREQ_DEFAULT,
  parameter int unsigned IW = id_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any_gnt
);

  always_comb begin
    gnt     = '0;
    idx     = '0;
    any_gnt = 1'b0;
    // Upper pass covers ptr..N-1, lower pass the wrapped range 0..ptr-1.
    for (int unsigned i = 0; i < N; i++) begin
      if (!any_gnt && req[i] && (32'(ptr) <= i)) begin
        any_gnt = 1'b1;
        gnt[i]  = 1'b1;
        idx     = IW'(i);
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (!any_gnt && req[i]) begin
        any_gnt = 1'b1;
        gnt[i]  = 1'b1;
        idx     = IW'(i);
      end
    end
  end

endmodule

// File: rtl/wall_fetch_arbiter.sv
// Shares one wall sprite ROM and palette among NREQ requesters, returning
// registered RGB tagged with the requester id ROM_LAT+1 cycles after grant.
module wall_fetch_arbiter
  import wall_pkg::*;
#(
  parameter  int unsigned NREQ    = NREQ_DEFAULT,
  parameter  int unsigned AW      = AW_DEFAULT,
  parameter  int unsigned ROM_LAT = 1,
  localparam int unsigned IW      = id_width(NREQ)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*AW-1:0] req_addr,
  output logic [NREQ-1:0]   gnt,
  output logic              rom_en,
  output logic [AW-1:0]     rom_addr,
  input  logic [3:0]        rom_data,
  output logic [3:0]        pal_index,
  input  logic [3:0]        pal_red,
  input  logic [3:0]        pal_green,
  input  logic [3:0]        pal_blue,
  output logic              rsp_valid,
  output logic [IW-1:0]     rsp_id,
  output logic [11:0]       rsp_rgb
);

  logic [IW-1:0]      ptr;
  logic [NREQ-1:0]    arb_gnt;
  logic [IW-1:0]      win_idx;
  logic               win_any;
  logic [ROM_LAT-1:0] vpipe;
  logic [IW-1:0]      idpipe [ROM_LAT];
  rgb_t               rsp_q;

  rr_arbiter #(.N(NREQ), .IW(IW)) u_arb (
    .req     (req),
    .ptr     (ptr),
    .gnt     (arb_gnt),
    .idx     (win_idx),
    .any_gnt (win_any)
  );

  // Grant is suppressed for the whole reset cycle so nothing enters the pipe.
  always_comb begin
    rom_en   = win_any && !Reset;
    gnt      = rom_en ? arb_gnt : '0;
    rom_addr = '0;
    if (rom_en) rom_addr = req_addr[32'(win_idx)*AW +: AW];
  end

  assign pal_index = rom_data;
  assign rsp_rgb   = rsp_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ptr <= '0;
    end else if (rom_en) begin
      ptr <= (32'(win_idx) == NREQ - 1) ? '0 : win_idx + IW'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      vpipe <= '0;
      for (int unsigned s = 0; s < ROM_LAT; s++) idpipe[s] <= '0;
    end else begin
      vpipe[0]  <= rom_en;
      idpipe[0] <= win_idx;
      for (int unsigned s = 1; s < ROM_LAT; s++) begin
        vpipe[s]  <= vpipe[s-1];
        idpipe[s] <= idpipe[s-1];
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_q     <= '0;
    end else begin
      rsp_valid <= vpipe[ROM_LAT-1];
      if (vpipe[ROM_LAT-1]) begin
        rsp_id <= idpipe[ROM_LAT-1];
        rsp_q  <= '{r: pal_red, g: pal_green, b: pal_blue};
      end
    end
  end

endmodule

// File: tb/tb_wall_fetch_arbiter.sv
// Bench for wall_fetch_arbiter: ROM_LAT=1 and ROM_LAT=3 instances share stimulus.
module tb_wall_fetch_arbiter;
  import wall_pkg::*;

  localparam int unsigned NREQ = 3;
  localparam int unsigned AW   = 10;
  localparam int unsigned IW   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*AW-1:0] req_addr;

  logic [NREQ-1:0] gnt_a, gnt_b;
  logic            rom_en_a, rom_en_b;
  logic [AW-1:0]   rom_addr_a, rom_addr_b;
  logic [3:0]      rom_data_a, rom_data_b, romb_s0, romb_s1;
  logic [3:0]      pal_index_a, pal_index_b;
  logic [3:0]      pr_a, pg_a, pb_a, pr_b, pg_b, pb_b;
  logic            rsp_valid_a, rsp_valid_b;
  logic [IW-1:0]   rsp_id_a, rsp_id_b;
  logic [11:0]     rsp_rgb_a, rsp_rgb_b;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [11:0] pal_lut(input logic [3:0] i);
    logic [11:0] c;
    case (i)
      4'h2:    c = 12'hFFF;
      4'h6:    c = 12'hABA;
      4'hE:    c = 12'hBCB;
      default: c = {i, ~i, i ^ 4'h5};
    endcase
    return c;
  endfunction

  assign {pr_a, pg_a, pb_a} = pal_lut(pal_index_a);
  assign {pr_b, pg_b, pb_b} = pal_lut(pal_index_b);

  // ROM contents: index = addr[3:0]
  always @(posedge clk) if (rom_en_a) rom_data_a <= rom_addr_a[3:0];
  always @(posedge clk) begin
    romb_s0    <= rom_addr_b[3:0];
    romb_s1    <= romb_s0;
    rom_data_b <= romb_s1;
  end

  wall_fetch_arbiter #(.NREQ(NREQ), .AW(AW), .ROM_LAT(1)) u_dut_l1 (
    .Clk(clk), .Reset(rst), .req(req), .req_addr(req_addr),
    .gnt(gnt_a), .rom_en(rom_en_a), .rom_addr(rom_addr_a), .rom_data(rom_data_a),
    .pal_index(pal_index_a), .pal_red(pr_a), .pal_green(pg_a), .pal_blue(pb_a),
    .rsp_valid(rsp_valid_a), .rsp_id(rsp_id_a), .rsp_rgb(rsp_rgb_a)
  );

  wall_fetch_arbiter #(.NREQ(NREQ), .AW(AW), .ROM_LAT(3)) u_dut_l3 (
    .Clk(clk), .Reset(rst), .req(req), .req_addr(req_addr),
    .gnt(gnt_b), .rom_en(rom_en_b), .rom_addr(rom_addr_b), .rom_data(rom_data_b),
    .pal_index(pal_index_b), .pal_red(pr_b), .pal_green(pg_b), .pal_blue(pb_b),
    .rsp_valid(rsp_valid_b), .rsp_id(rsp_id_b), .rsp_rgb(rsp_rgb_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: pointer, and per-latency schedule of responses keyed by cycle.
  int          ptr = 0;
  int          cyc = 0;
  int          lat [2] = '{1, 3};
  bit          sv   [2][64];
  int          sid  [2][64];
  logic [3:0]  sidx [2][64];
  logic        exp_v   [2] = '{1'b0, 1'b0};
  logic [1:0]  exp_id  [2] = '{2'd0, 2'd0};
  logic [11:0] exp_rgb [2] = '{12'h0, 12'h0};

  function automatic logic [NREQ*AW-1:0] pack(input logic [AW-1:0] a0, a1, a2);
    return {a2, a1, a0};
  endfunction

  task automatic run_cycle(input logic r_rst, input logic [NREQ-1:0] r_req,
                           input logic [NREQ*AW-1:0] r_addr);
    int w;
    int slot;
    logic [NREQ-1:0] eg;
    logic [AW-1:0]   ea;
    @(negedge clk);
    chk("rsp_valid_l1", rsp_valid_a, exp_v[0]);
    chk("rsp_id_l1",    rsp_id_a,    exp_id[0]);
    chk("rsp_rgb_l1",   rsp_rgb_a,   exp_rgb[0]);
    chk("rsp_valid_l3", rsp_valid_b, exp_v[1]);
    chk("rsp_id_l3",    rsp_id_b,    exp_id[1]);
    chk("rsp_rgb_l3",   rsp_rgb_b,   exp_rgb[1]);
    rst = r_rst; req = r_req; req_addr = r_addr;
    #1;
    w = -1;
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (ptr + k) % NREQ;
      if (w < 0 && r_req[i]) w = i;
    end
    if (r_rst) w = -1;
    eg = '0; ea = '0;
    if (w >= 0) begin
      eg[w] = 1'b1;
      ea = r_addr[w*AW +: AW];
    end
    chk("gnt_l1", gnt_a, eg);
    chk("rom_en_l1", rom_en_a, w >= 0);
    chk("rom_addr_l1", rom_addr_a, ea);
    chk("gnt_l3", gnt_b, eg);
    chk("rom_en_l3", rom_en_b, w >= 0);
    chk("rom_addr_l3", rom_addr_b, ea);
    for (int d = 0; d < 2; d++) begin
      slot = cyc % 64;
      if (r_rst) begin
        for (int s = 0; s < 64; s++) sv[d][s] = 1'b0;
        exp_v[d] = 1'b0; exp_id[d] = '0; exp_rgb[d] = '0;
      end else begin
        if (sv[d][slot]) begin
          chk(d == 0 ? "pal_index_l1" : "pal_index_l3",
              d == 0 ? pal_index_a : pal_index_b, sidx[d][slot]);
          exp_v[d]   = 1'b1;
          exp_id[d]  = 2'(sid[d][slot]);
          exp_rgb[d] = pal_lut(sidx[d][slot]);
          sv[d][slot] = 1'b0;
        end else begin
          exp_v[d] = 1'b0;
        end
        if (w >= 0) begin
          slot = (cyc + lat[d]) % 64;
          sv[d][slot]   = 1'b1;
          sid[d][slot]  = w;
          sidx[d][slot] = ea[3:0];
        end
      end
    end
    if (r_rst) ptr = 0;
    else if (w >= 0) ptr = (w + 1) % NREQ;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) run_cycle(1'b0, '0, '0);
  endtask

  initial begin
    logic [NREQ*AW-1:0] a3;
    rst = 1'b1; req = '0; req_addr = '0;
    @(posedge clk);
    run_cycle(1'b1, '0, '0);
    // single request, palette entry 0xFFF
    run_cycle(1'b0, 3'b001, pack(10'h002, 10'h000, 10'h000));
    idle(4);
    // all requesting: strict rotation
    a3 = pack(10'h002, 10'h006, 10'h00E);
    for (int i = 0; i < 6; i++) run_cycle(1'b0, 3'b111, a3);
    idle(5);
    // wrap from pointer 2
    run_cycle(1'b1, '0, '0);
    run_cycle(1'b0, 3'b010, a3);
    run_cycle(1'b0, 3'b011, a3);
    run_cycle(1'b0, 3'b011, a3);
    idle(5);
    // lone request from 2, then idle
    run_cycle(1'b0, 3'b100, pack(10'h000, 10'h000, 10'h006));
    idle(5);
    // reset during back-to-back traffic
    run_cycle(1'b0, 3'b111, a3);
    run_cycle(1'b1, 3'b111, a3);
    idle(5);
    run_cycle(1'b0, 3'b111, a3);
    idle(5);
    // latency-3 lookup of 0x00E
    run_cycle(1'b0, 3'b010, pack(10'h000, 10'h00E, 10'h000));
    idle(6);
    for (int i = 0; i < 600; i++) begin
      run_cycle($urandom_range(0, 49) == 0, NREQ'($urandom),
                pack(AW'($urandom), AW'($urandom), AW'($urandom)));
    end
    idle(6);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
